uart_cmd_ctrl: RTL and testbench

Command/response sequencer between the host UART and the core logic. It drives the UART receiver and transmitter handshakes directly. Incoming bytes are assembled into 24-bit commands (opcode, data high, data low). A 16-bit response is serialized back as two bytes, high byte first. Inter-byte timeouts and framing errors are detected so a dropped byte never misaligns later commands.

---
 rtl/uart_cmd_ctrl_if.sv | 35 +++
 rtl/uart_cmd_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_ctrl_if.sv
// Bundles the UART byte handshakes and the command/response handshakes of
// uart_cmd_ctrl into one interface.
//   slave  : controller side (uart_cmd_ctrl)
//   master : environment side (UART receiver/transmitter plus core logic)
// Signals:
//   rx_data/rx_rdy/clr_rx_rdy  : receiver byte handshake
//   tx_data/trmt/tx_done       : transmitter byte handshake
//   cmd/cmd_rdy/clr_cmd_rdy    : assembled 24-bit command to the core
//   resp_req/resp_data         : 16-bit response request from the core
//   resp_busy/cmd_err          : response in progress / frame error pulse
interface uart_cmd_ctrl_if;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        clr_rx_rdy;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        resp_req;
    logic [15:0] resp_data;
    logic        resp_busy;
    logic        cmd_err;

    modport slave (
        input  rx_data, rx_rdy, tx_done, clr_cmd_rdy, resp_req, resp_data,
        output clr_rx_rdy, tx_data, trmt, cmd, cmd_rdy, resp_busy, cmd_err
    );

    modport master (
        output rx_data, rx_rdy, tx_done, clr_cmd_rdy, resp_req, resp_data,
        input  clr_rx_rdy, tx_data, trmt, cmd, cmd_rdy, resp_busy, cmd_err
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Command/response sequencer between the host UART and the core logic.
// Assembles received bytes into 24-bit commands {opcode, data_hi, data_lo}
// with an inter-byte timeout, and serializes 16-bit responses high byte first.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : uart_cmd_ctrl_if.slave (UART handshakes, command and response)
// Parameter:
//   TIMEOUT_CYCLES : idle cycles allowed between bytes of one command (>= 4)
// Optional feature (macro UART_CMD_CHKSUM_EN):
//   adds a checksum byte ~(op+hi+lo) to received commands and a checksum
//   byte ~(hi+lo) after each response.
module uart_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic           clk,
    input  logic           rst,
    uart_cmd_ctrl_if.slave bus
);

    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {RX_OP, RX_HI, RX_LO, RX_CS} rx_state_e;
    typedef enum logic [1:0] {TX_IDLE, TX_HI, TX_LO, TX_CS} tx_state_e;

    rx_state_e        rx_state_q, rx_state_d;
    tx_state_e        tx_state_q, tx_state_d;
    logic [7:0]       op_q, op_d;
    logic [7:0]       hi_q, hi_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             clr_rx_rdy_q, clr_rx_rdy_d;
    logic [23:0]      cmd_q, cmd_d;
    logic             cmd_rdy_q, cmd_rdy_d;
    logic             cmd_err_q, cmd_err_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             trmt_q, trmt_d;
    logic [7:0]       resp_lo_q, resp_lo_d;
    logic [1:0]       mask_q, mask_d;
    logic             resp_busy_q, resp_busy_d;
    logic             rx_accept;
    logic             tx_done_ok;
`ifdef UART_CMD_CHKSUM_EN
    logic [7:0]       lo_q, lo_d;
    logic [7:0]       resp_cs_q, resp_cs_d;
    logic [7:0]       rx_cs_c;

    assign rx_cs_c = ~(op_q + hi_q + lo_q);
`endif

    // Stale rx_rdy is still high on the clr_rx_rdy cycle, so it is masked.
    assign rx_accept  = bus.rx_rdy & ~clr_rx_rdy_q;
    // A done seen on the trmt cycle or the one after belongs to the previous byte.
    assign tx_done_ok = bus.tx_done & (mask_q == 2'd0);

    // Next-state and output computation for both FSMs.
    always_comb begin
        rx_state_d   = rx_state_q;
        tx_state_d   = tx_state_q;
        op_d         = op_q;
        hi_d         = hi_q;
        tmo_d        = tmo_q;
        clr_rx_rdy_d = rx_accept;
        cmd_d        = cmd_q;
        cmd_rdy_d    = cmd_rdy_q;
        cmd_err_d    = 1'b0;
        tx_data_d    = tx_data_q;
        trmt_d       = 1'b0;
        resp_lo_d    = resp_lo_q;
        mask_d       = (mask_q != 2'd0) ? mask_q - 2'd1 : 2'd0;
`ifdef UART_CMD_CHKSUM_EN
        lo_d         = lo_q;
        resp_cs_d    = resp_cs_q;
`endif

        // Receive side; a completion below overrides this clear.
        if (bus.clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end
        tmo_d = (rx_state_q == RX_OP) ? '0 : tmo_q + TMO_W'(1);

        if (rx_accept) begin
            tmo_d = '0;
            case (rx_state_q)
                RX_OP: begin
                    op_d       = bus.rx_data;
                    rx_state_d = RX_HI;
                end
                RX_HI: begin
                    hi_d       = bus.rx_data;
                    rx_state_d = RX_LO;
                end
`ifdef UART_CMD_CHKSUM_EN
                RX_LO: begin
                    lo_d       = bus.rx_data;
                    rx_state_d = RX_CS;
                end
                RX_CS: begin
                    rx_state_d = RX_OP;
                    if (bus.rx_data == rx_cs_c) begin
                        cmd_d     = {op_q, hi_q, lo_q};
                        cmd_rdy_d = 1'b1;
                        cmd_err_d = cmd_rdy_q;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
`else
                RX_LO: begin
                    rx_state_d = RX_OP;
                    cmd_d      = {op_q, hi_q, bus.rx_data};
                    cmd_rdy_d  = 1'b1;
                    cmd_err_d  = cmd_rdy_q;
                end
`endif
                default: rx_state_d = RX_OP;
            endcase
        end else if ((rx_state_q != RX_OP) && (tmo_q == TMO_LAST)) begin
            // Partial frame dropped so the next byte starts a fresh command.
            rx_state_d = RX_OP;
            tmo_d      = '0;
            cmd_err_d  = 1'b1;
        end

        // Transmit side.
        case (tx_state_q)
            TX_IDLE: begin
                if (bus.resp_req) begin
                    tx_data_d  = bus.resp_data[15:8];
                    resp_lo_d  = bus.resp_data[7:0];
`ifdef UART_CMD_CHKSUM_EN
                    resp_cs_d  = ~(bus.resp_data[15:8] + bus.resp_data[7:0]);
`endif
                    trmt_d     = 1'b1;
                    tx_state_d = TX_HI;
                end
            end
            TX_HI: begin
                if (tx_done_ok) begin
                    tx_data_d  = resp_lo_q;
                    trmt_d     = 1'b1;
                    tx_state_d = TX_LO;
                end
            end
`ifdef UART_CMD_CHKSUM_EN
            TX_LO: begin
                if (tx_done_ok) begin
                    tx_data_d  = resp_cs_q;
                    trmt_d     = 1'b1;
                    tx_state_d = TX_CS;
                end
            end
            TX_CS: begin
                if (tx_done_ok) begin
                    tx_state_d = TX_IDLE;
                end
            end
`else
            TX_LO: begin
                if (tx_done_ok) begin
                    tx_state_d = TX_IDLE;
                end
            end
`endif
            default: tx_state_d = TX_IDLE;
        endcase

        if (trmt_d) begin
            mask_d = 2'd2;
        end
        resp_busy_d = (tx_state_d != TX_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q   <= RX_OP;
            tx_state_q   <= TX_IDLE;
            op_q         <= '0;
            hi_q         <= '0;
            tmo_q        <= '0;
            clr_rx_rdy_q <= 1'b0;
            cmd_q        <= '0;
            cmd_rdy_q    <= 1'b0;
            cmd_err_q    <= 1'b0;
            tx_data_q    <= '0;
            trmt_q       <= 1'b0;
            resp_lo_q    <= '0;
            mask_q       <= '0;
            resp_busy_q  <= 1'b0;
`ifdef UART_CMD_CHKSUM_EN
            lo_q         <= '0;
            resp_cs_q    <= '0;
`endif
        end else begin
            rx_state_q   <= rx_state_d;
            tx_state_q   <= tx_state_d;
            op_q         <= op_d;
            hi_q         <= hi_d;
            tmo_q        <= tmo_d;
            clr_rx_rdy_q <= clr_rx_rdy_d;
            cmd_q        <= cmd_d;
            cmd_rdy_q    <= cmd_rdy_d;
            cmd_err_q    <= cmd_err_d;
            tx_data_q    <= tx_data_d;
            trmt_q       <= trmt_d;
            resp_lo_q    <= resp_lo_d;
            mask_q       <= mask_d;
            resp_busy_q  <= resp_busy_d;
`ifdef UART_CMD_CHKSUM_EN
            lo_q         <= lo_d;
            resp_cs_q    <= resp_cs_d;
`endif
        end
    end

    assign bus.clr_rx_rdy = clr_rx_rdy_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.trmt       = trmt_q;
    assign bus.cmd        = cmd_q;
    assign bus.cmd_rdy    = cmd_rdy_q;
    assign bus.resp_busy  = resp_busy_q;
    assign bus.cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a frame-level reference model.
module tb_uart_cmd_ctrl;

    localparam int unsigned TMO = 20;
`ifdef UART_CMD_CHKSUM_EN
    localparam int FL = 4;
`else
    localparam int FL = 3;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_cmd_ctrl_if bus();

    uart_cmd_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // stimulus queues and environment state
    logic [7:0] rxq[$];
    int         gapq[$];
    int         rx_gap = 0;
    logic       rx_drop = 1'b0;
    logic       clr_with_last = 1'b0;
    logic       rnd_on = 1'b0;
    int         fixed_lat = 0;
    logic       tx_phase = 1'b0;
    int         tx_hold = 0;
    int         tx_lat = 0;

    // reference model state
    logic [7:0]  fq[$];
    int          idle = 0;
    logic        m_clr = 1'b0;
    logic [23:0] m_cmd = '0;
    logic        m_rdy = 1'b0;
    logic [7:0]  bq[$];
    logic        m_busy = 1'b0;
    int          mcnt = 0;
    logic [7:0]  m_tx = '0;

    // observations for directed checks
    logic       prev_clr_obs = 1'b0;
    int         err_seen = 0;
    logic [7:0] trmt_log[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input int gap);
        rxq.push_back(b);
        gapq.push_back(gap);
    endtask

    task automatic push_cmd(input logic [7:0] op, input logic [7:0] hi, input logic [7:0] lo,
                            input int gap, input logic bad_cs);
        logic [7:0] cs;
        cs = ~(op + hi + lo);
        push_byte(op, gap);
        push_byte(hi, gap);
`ifdef UART_CMD_CHKSUM_EN
        push_byte(lo, gap);
        push_byte(bad_cs ? cs ^ 8'h5A : cs, gap);
`else
        push_byte(lo, bad_cs ? gap : gap);
`endif
    endtask

    // One clock: model update, comparisons, then environment drives next inputs.
    task automatic step();
        logic        s_rst, s_rx_rdy, s_tx_done, s_req, s_clrc;
        logic [7:0]  s_rx;
        logic [15:0] s_resp;
        logic        exp_trmt, exp_err, set_rdy, masked, acc;
        logic [7:0]  cs;
        s_rst     = rst;
        s_rx_rdy  = bus.rx_rdy;
        s_rx      = bus.rx_data;
        s_tx_done = bus.tx_done;
        s_req     = bus.resp_req;
        s_resp    = bus.resp_data;
        s_clrc    = bus.clr_cmd_rdy;
        @(posedge clk);
        #1;
        exp_trmt = 1'b0;
        exp_err  = 1'b0;
        set_rdy  = 1'b0;
        if (s_rst) begin
            fq.delete();
            bq.delete();
            idle = 0; m_clr = 1'b0; m_cmd = '0; m_rdy = 1'b0;
            m_busy = 1'b0; mcnt = 0; m_tx = '0;
        end else begin
            acc   = s_rx_rdy && !m_clr;
            m_clr = acc;
            if (acc) begin
                fq.push_back(s_rx);
                idle = 0;
                if (fq.size() == FL) begin
`ifdef UART_CMD_CHKSUM_EN
                    cs = ~(fq[0] + fq[1] + fq[2]);
                    if (fq[3] == cs) set_rdy = 1'b1;
                    else exp_err = 1'b1;
`else
                    cs = '0;
                    set_rdy = 1'b1;
`endif
                    if (set_rdy) begin
                        if (m_rdy) exp_err = 1'b1;
                        m_cmd = {fq[0], fq[1], fq[2]};
                    end
                    fq.delete();
                end
            end else if (fq.size() != 0) begin
                idle++;
                if (idle == TMO) begin
                    exp_err = 1'b1;
                    fq.delete();
                end
            end
            if (set_rdy) m_rdy = 1'b1;
            else if (s_clrc) m_rdy = 1'b0;

            masked = (mcnt > 0);
            if (mcnt > 0) mcnt--;
            if (!m_busy) begin
                if (s_req) begin
                    bq.push_back(s_resp[15:8]);
                    bq.push_back(s_resp[7:0]);
`ifdef UART_CMD_CHKSUM_EN
                    cs = ~(s_resp[15:8] + s_resp[7:0]);
                    bq.push_back(cs);
`endif
                    m_busy = 1'b1;
                    exp_trmt = 1'b1;
                end
            end else if (s_tx_done && !masked) begin
                if (bq.size() > 0) exp_trmt = 1'b1;
                else m_busy = 1'b0;
            end
            if (exp_trmt) begin
                m_tx = bq.pop_front();
                mcnt = 2;
            end
        end

        check_eq("clr_rx_rdy", bus.clr_rx_rdy, m_clr);
        check_eq("cmd_rdy", bus.cmd_rdy, m_rdy);
        check_eq("cmd", bus.cmd, m_cmd);
        check_eq("cmd_err", bus.cmd_err, exp_err);
        check_eq("trmt", bus.trmt, exp_trmt);
        check_eq("tx_data", bus.tx_data, m_tx);
        check_eq("resp_busy", bus.resp_busy, m_busy);
        if (bus.clr_rx_rdy) check_eq("clr_rx_rdy_width", prev_clr_obs, 1'b0);
        prev_clr_obs = bus.clr_rx_rdy;
        if (bus.cmd_err) err_seen++;
        if (bus.trmt) trmt_log.push_back(bus.tx_data);

        // core-side inputs
        if (rnd_on) begin
            bus.resp_req    = ($urandom_range(0, 7) == 0);
            bus.resp_data   = 16'($urandom);
            bus.clr_cmd_rdy = ($urandom_range(0, 3) == 0);
            rst             = ($urandom_range(0, 599) == 0);
            if (rxq.size() == 0)
                push_byte(8'($urandom), ($urandom_range(0, 9) < 7) ? $urandom_range(0, 5)
                                                                   : $urandom_range(15, 30));
        end else begin
            bus.resp_req    = 1'b0;
            bus.clr_cmd_rdy = 1'b0;
        end

        // receiver: rx_rdy stays high through the clr cycle, then drops
        if (rx_drop) begin
            bus.rx_rdy = 1'b0;
            rx_drop    = 1'b0;
        end else if (!bus.rx_rdy) begin
            if (rx_gap > 0) begin
                rx_gap--;
            end else if (rxq.size() > 0) begin
                bus.rx_data = rxq.pop_front();
                rx_gap      = gapq.pop_front();
                bus.rx_rdy  = 1'b1;
                if (rxq.size() == 0 && clr_with_last) begin
                    bus.clr_cmd_rdy = 1'b1;
                    clr_with_last   = 1'b0;
                end
            end
        end
        if (bus.clr_rx_rdy) rx_drop = 1'b1;

        // transmitter: done may stay stale briefly after trmt, then low, then high
        if (bus.trmt) begin
            tx_phase = 1'b1;
            tx_hold  = $urandom_range(0, 1);
            tx_lat   = (fixed_lat > 0) ? fixed_lat - 2 : $urandom_range(1, 12);
        end else if (tx_phase) begin
            if (tx_hold > 0) begin
                tx_hold--;
            end else begin
                bus.tx_done = 1'b0;
                if (tx_lat > 0) tx_lat--;
                else begin
                    bus.tx_done = 1'b1;
                    tx_phase    = 1'b0;
                end
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_idle_outputs(input string pfx);
        check_eq({pfx, "_cmd"}, bus.cmd, 24'h0);
        check_eq({pfx, "_cmd_rdy"}, bus.cmd_rdy, 1'b0);
        check_eq({pfx, "_cmd_err"}, bus.cmd_err, 1'b0);
        check_eq({pfx, "_clr_rx_rdy"}, bus.clr_rx_rdy, 1'b0);
        check_eq({pfx, "_trmt"}, bus.trmt, 1'b0);
        check_eq({pfx, "_tx_data"}, bus.tx_data, 8'h00);
        check_eq({pfx, "_resp_busy"}, bus.resp_busy, 1'b0);
    endtask

    initial begin
        int e0;
        rst             = 1'b1;
        bus.rx_data     = '0;
        bus.rx_rdy      = 1'b0;
        bus.tx_done     = 1'b0;
        bus.clr_cmd_rdy = 1'b0;
        bus.resp_req    = 1'b0;
        bus.resp_data   = '0;
        run(2);
        rst = 1'b0;
        check_idle_outputs("reset");

        // basic command
        push_cmd(8'h12, 8'h34, 8'h56, 1, 1'b0);
        run(30);
        check_eq("basic_cmd", bus.cmd, 24'h123456);
        check_eq("basic_cmd_rdy", bus.cmd_rdy, 1'b1);
        bus.clr_cmd_rdy = 1'b1;
        step();
        check_eq("clr_cmd_rdy", bus.cmd_rdy, 1'b0);

        // response with fixed 10-cycle transmitter
        fixed_lat = 10;
        trmt_log.delete();
        bus.resp_req  = 1'b1;
        bus.resp_data = 16'hBEEF;
        step();
        check_eq("resp_busy_start", bus.resp_busy, 1'b1);
        run(60);
        check_eq("resp_trmt_count", trmt_log.size(), FL - 1);
        if (trmt_log.size() >= 2) begin
            check_eq("resp_byte_hi", trmt_log[0], 8'hBE);
            check_eq("resp_byte_lo", trmt_log[1], 8'hEF);
        end
        check_eq("resp_busy_end", bus.resp_busy, 1'b0);

        // inter-byte timeout then a clean frame
        e0 = err_seen;
        push_byte(8'h01, 1);
        push_byte(8'h02, 25);
        push_cmd(8'hAA, 8'hBB, 8'hCC, 1, 1'b0);
        run(80);
        check_eq("timeout_err_count", err_seen - e0, 1);
        check_eq("timeout_then_cmd", bus.cmd, 24'hAABBCC);

        // overrun and set-over-clear priority
        bus.clr_cmd_rdy = 1'b1;
        step();
        e0 = err_seen;
        push_cmd(8'h11, 8'h22, 8'h33, 2, 1'b0);
        push_cmd(8'h44, 8'h55, 8'h66, 2, 1'b0);
        run(40);
        check_eq("overrun_err_count", err_seen - e0, 1);
        check_eq("overrun_cmd", bus.cmd, 24'h445566);
        clr_with_last = 1'b1;
        push_cmd(8'h77, 8'h88, 8'h99, 2, 1'b0);
        run(30);
        check_eq("set_wins_rdy", bus.cmd_rdy, 1'b1);
        check_eq("set_wins_cmd", bus.cmd, 24'h778899);

`ifdef UART_CMD_CHKSUM_EN
        bus.clr_cmd_rdy = 1'b1;
        step();
        push_cmd(8'h10, 8'h20, 8'h30, 1, 1'b0);
        run(30);
        check_eq("cs_good_cmd", bus.cmd, 24'h102030);
        bus.clr_cmd_rdy = 1'b1;
        step();
        e0 = err_seen;
        push_byte(8'h10, 1); push_byte(8'h20, 1); push_byte(8'h30, 1); push_byte(8'h00, 1);
        run(30);
        check_eq("cs_bad_err", err_seen - e0, 1);
        check_eq("cs_bad_rdy", bus.cmd_rdy, 1'b0);
        trmt_log.delete();
        bus.resp_req  = 1'b1;
        bus.resp_data = 16'h0102;
        step();
        run(80);
        check_eq("cs_resp_count", trmt_log.size(), 3);
        if (trmt_log.size() == 3) begin
            check_eq("cs_resp_b0", trmt_log[0], 8'h01);
            check_eq("cs_resp_b1", trmt_log[1], 8'h02);
            check_eq("cs_resp_b2", trmt_log[2], 8'hFC);
        end
`endif

        // reset mid-frame, then a fresh frame must align
        push_byte(8'hA1, 1);
        push_byte(8'hA2, 1);
        run(12);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle_outputs("midrst");
        push_cmd(8'hB1, 8'hB2, 8'hB3, 1, 1'b0);
        run(30);
        check_eq("midrst_cmd", bus.cmd, 24'hB1B2B3);
        check_eq("midrst_cmd_rdy", bus.cmd_rdy, 1'b1);

        // random traffic
        fixed_lat = 0;
        rnd_on    = 1'b1;
        run(5000);
        rnd_on = 1'b0;
        rst    = 1'b0;
        run(150);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
